// File: rtl/lpm_outser_pkg.sv
// Shared types and constants for the lpm_outser serializer.
// State encoding, slice-order names and counter sizing.
package lpm_outser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam string DIR_LSB = "LSB_FIRST";
    localparam string DIR_MSB = "MSB_FIRST";

    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/lpm_outser_hold.sv
// One-word holding register with full flag.
// Parks the next word while the shifter is still busy.
module lpm_outser_hold
    import lpm_outser_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         sclr,
    input  logic         wr_en,
    input  logic         take,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    // Fill on write, empty when the shifter takes the word.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (take) begin
            full_d = 1'b0;
        end
        if (wr_en) begin
            data_d = wr_data;
            full_d = 1'b1;
        end
    end

    // Register with synchronous clear.
    always_ff @(posedge clock) begin
        if (sclr) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/lpm_outser.sv
// Parallel-to-serial converter with one-word look-ahead.
// Emits lpm_width/lpm_outwidth slices per word with no gaps.
module lpm_outser
    import lpm_outser_pkg::*;
#(
    parameter string lpm_type      = "lpm_outser",
    parameter int    lpm_width     = 8,
    parameter int    lpm_outwidth  = 1,
    parameter string lpm_direction = "LSB_FIRST",
    parameter string lpm_hint      = "UNUSED"
) (
    input  logic                    clock,
    input  logic                    sclr,
    input  logic [lpm_width-1:0]    data,
    input  logic                    load,
    output logic                    ready,
    output logic [lpm_outwidth-1:0] q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int NSLICE = lpm_width / lpm_outwidth;
    localparam int CW     = cnt_width(NSLICE);
    localparam bit MSB    = (lpm_direction == DIR_MSB);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if ((lpm_width % lpm_outwidth) != 0 || lpm_type == "" || lpm_hint == ""
        || (lpm_direction != DIR_LSB && lpm_direction != DIR_MSB)) begin : g_bad_cfg
        $error("lpm_outser: illegal parameter set");
    end

    state_e               state_q, state_d;
    logic [lpm_width-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 hold_full;
    logic                 hold_wr;
    logic                 hold_take;
    logic [lpm_width-1:0] hold_data;
    logic                 accept;
    logic                 last;

    assign accept = load & ~hold_full;
    assign last   = (state_q == ST_SHIFT) && (cnt_q == LAST);

    // Next state: shift, refill from HOLD or input, or fall back to idle.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hold_wr   = 1'b0;
        hold_take = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = data;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (!last) begin
                    cnt_d   = cnt_q + CW'(1);
                    shreg_d = MSB ? (shreg_q << lpm_outwidth)
                                  : (shreg_q >> lpm_outwidth);
                    hold_wr = accept;
                end else if (hold_full) begin
                    shreg_d   = hold_data;
                    cnt_d     = '0;
                    hold_take = 1'b1;
                end else if (accept) begin
                    shreg_d = data;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State, shifter and slice counter with synchronous clear.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    lpm_outser_hold #(
        .W(lpm_width)
    ) u_hold (
        .clock  (clock),
        .sclr   (sclr),
        .wr_en  (hold_wr),
        .take   (hold_take),
        .wr_data(data),
        .rd_data(hold_data),
        .full   (hold_full)
    );

    assign ready   = ~hold_full;
    assign q_valid = (state_q == ST_SHIFT);
    assign busy    = q_valid | hold_full;
    assign q       = !q_valid ? '0
                   : MSB ? shreg_q[lpm_width-1 -: lpm_outwidth]
                         : shreg_q[lpm_outwidth-1:0];

endmodule

// File: tb/tb_lpm_outser.sv
// Scoreboard bench for lpm_outser in three configurations.
// Queue-level reference model plus directed sequences.
module tb_lpm_outser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int    W   = (g == 2) ? 4 : 8;
        localparam int    OW  = (g == 2) ? 4 : 2;
        localparam int    NS  = W / OW;
        localparam bit    MSB = (g == 1);
        localparam string DIR = MSB ? "MSB_FIRST" : "LSB_FIRST";

        logic          sclr;
        logic          load;
        logic [W-1:0]  data;
        logic          ready;
        logic          q_valid;
        logic          busy;
        logic [OW-1:0] q;

        lpm_outser #(
            .lpm_width    (W),
            .lpm_outwidth (OW),
            .lpm_direction(DIR)
        ) u_dut (
            .clock  (clk),
            .sclr   (sclr),
            .data   (data),
            .load   (load),
            .ready  (ready),
            .q      (q),
            .q_valid(q_valid),
            .busy   (busy)
        );

        int unsigned sb[$];
        int          log_q[$];
        bit          vhist[$];
        bit          rhist[$];
        bit          chk_en;
        bit          exp_ready;
        bit          acc;

        function automatic int unsigned slice(input int unsigned w, input int k);
            int sh;
            sh = MSB ? (NS - 1 - k) * OW : k * OW;
            return (w >> sh) & ((32'd1 << OW) - 1);
        endfunction

        function automatic int longest(input int from);
            int best, cur;
            best = 0;
            cur = 0;
            for (int i = from; i < vhist.size(); i++) begin
                cur = vhist[i] ? cur + 1 : 0;
                if (cur > best) best = cur;
            end
            return best;
        endfunction

        function automatic int ones(input int from);
            int n;
            n = 0;
            for (int i = from; i < vhist.size(); i++) n += int'(vhist[i]);
            return n;
        endfunction

        function automatic int lows(input int from);
            int n;
            n = 0;
            for (int i = from; i < rhist.size(); i++) n += int'(!rhist[i]);
            return n;
        endfunction

        // Model: accepted word expands into its slices; clear drops everything.
        always @(posedge clk) begin
            acc <= 1'b0;
            if (sclr) begin
                sb.delete();
            end else if (load && exp_ready) begin
                acc <= 1'b1;
                for (int k = 0; k < NS; k++) sb.push_back(slice(32'(data), k));
            end
        end

        // Monitor: compare DUT against the head of the expected slice queue.
        always @(negedge clk) begin
            exp_ready <= (sb.size() <= NS);
            if (chk_en) begin
                chk($sformatf("c%0d_valid", g), 32'(q_valid), 32'(sb.size() != 0));
                chk($sformatf("c%0d_ready", g), 32'(ready), 32'(sb.size() <= NS));
                chk($sformatf("c%0d_busy", g), 32'(busy), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    chk($sformatf("c%0d_q", g), 32'(q), sb[0]);
                    void'(sb.pop_front());
                end else begin
                    chk($sformatf("c%0d_q_idle", g), 32'(q), 32'd0);
                end
                if (q_valid) log_q.push_back(int'(q));
                vhist.push_back(q_valid);
                rhist.push_back(ready);
            end
        end

        task automatic step(input bit l, input int unsigned d, input bit r);
            load = l;
            data = W'(d);
            sclr = r;
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
        endtask

        task automatic offer(input int unsigned d);
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                step(1'b1, d, 1'b0);
                got = acc;
            end
            load = 1'b0;
            chk($sformatf("c%0d_offer_accepted", g), 32'(got), 32'd1);
        endtask

        task automatic do_reset();
            step(1'b0, 0, 1'b1);
            chk_en = 1'b1;
            step(1'b0, 0, 1'b1);
            step(1'b0, 0, 1'b0);
        endtask

        task automatic rand_run(input int n);
            for (int i = 0; i < n; i++)
                step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 59) == 0);
        endtask

        task automatic chk_seq(input string nm, input int from, input int n,
                               input int e0, input int e1, input int e2, input int e3);
            int e [4];
            e[0] = e0;
            e[1] = e1;
            e[2] = e2;
            e[3] = e3;
            for (int i = 0; i < n; i++)
                chk($sformatf("c%0d_%s_%0d", g, nm, i),
                    (from + i < log_q.size()) ? log_q[from + i] : -1, e[i]);
        endtask

        if (g == 0) begin : g_t0
            initial begin
                int s, v;
                do_reset();
                s = log_q.size();
                v = vhist.size();
                offer(32'hB4);
                idle(6);
                chk_seq("lsb_b4", s, 4, 0, 1, 3, 2);
                chk("c0_lsb_b4_run", longest(v), 4);
                chk("c0_lsb_b4_cnt", ones(v), 4);

                s = log_q.size();
                v = vhist.size();
                offer(32'h1B);
                offer(32'hE4);
                offer(32'hFF);
                idle(14);
                chk("c0_b2b_run", longest(v), 12);
                chk("c0_b2b_cnt", ones(v), 12);
                chk("c0_b2b_rdy_low", lows(v), 6);
                chk_seq("b2b_head", s, 4, 3, 2, 1, 0);
                chk_seq("b2b_mid", s + 4, 4, 0, 1, 2, 3);

                s = log_q.size();
                v = vhist.size();
                offer(32'h00);
                idle(3);
                offer(32'h55);
                idle(8);
                chk("c0_direct_run", longest(v), 8);
                chk("c0_direct_rdy_low", lows(v), 0);
                chk_seq("direct_55", s + 4, 4, 1, 1, 1, 1);

                offer(32'hA5);
                offer(32'h3C);
                idle(1);
                chk("c0_pre_rst_q", 32'(q), 2);
                chk("c0_pre_rst_ready", 32'(ready), 0);
                step(1'b0, $urandom, 1'b1);
                chk("c0_rst_q", 32'(q), 0);
                chk("c0_rst_valid", 32'(q_valid), 0);
                chk("c0_rst_ready", 32'(ready), 1);
                chk("c0_rst_busy", 32'(busy), 0);
                v = vhist.size();
                idle(10);
                chk("c0_rst_quiet", ones(v), 0);

                rand_run(300);
                done[0] = 1'b1;
            end
        end else if (g == 1) begin : g_t1
            initial begin
                int s, v;
                do_reset();
                s = log_q.size();
                v = vhist.size();
                offer(32'hB4);
                idle(6);
                chk_seq("msb_b4", s, 4, 2, 3, 1, 0);
                chk("c1_msb_b4_run", longest(v), 4);
                rand_run(300);
                done[1] = 1'b1;
            end
        end else begin : g_t2
            initial begin
                int s, v;
                do_reset();
                s = log_q.size();
                v = vhist.size();
                offer(32'h1);
                offer(32'h2);
                offer(32'h3);
                idle(4);
                chk_seq("w4_seq", s, 3, 1, 2, 3, -1);
                chk("c2_w4_run", longest(v), 3);
                chk("c2_w4_cnt", ones(v), 3);
                rand_run(300);
                done[2] = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(done[0] && done[1] && done[2]); i++)
            @(posedge clk);
        if (!(done[0] && done[1] && done[2])) begin
            checks++;
            errors++;
            $display("FAIL timeout: done=%0d%0d%0d, want 111", done[0], done[1], done[2]);
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
